// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: holds the PC, fetches one word at a time over a
// request/response handshake and computes the next PC when the held instruction retires.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        br_taken,
    input  logic        jal,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2,
        StFault = 2'd3
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e      state_d, state_q;
    logic [31:0] pc_d, pc_q;
    logic [31:0] instr_d, instr_q;
    logic        valid_d, valid_q;
    logic        fault_d, fault_q;
    logic [31:0] next_pc;

    // Redirect priority: jalr > jal > br_taken > sequential.
    always_comb begin
        if (jalr) begin
            next_pc = (rs1_val + imm) & 32'hFFFF_FFFE;
        end else if (jal || br_taken) begin
            next_pc = pc_q + imm;
        end else begin
            next_pc = pc_q + 32'd4;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (retire) begin
                    valid_d = 1'b0;
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        state_d = StFetch;
                    end else begin
                        fault_d = 1'b1;
                        state_d = StFault;
                    end
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    assign imem_req    = (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all checked every
// cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        retire = 1'b0;
    logic        br_taken = 1'b0;
    logic        jal = 1'b0;
    logic        jalr = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] rs1_val = '0;
    logic        fetch_fault;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .retire      (retire),
        .br_taken    (br_taken),
        .jal         (jal),
        .jalr        (jalr),
        .imm         (imm),
        .rs1_val     (rs1_val),
        .fetch_fault (fetch_fault)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: what the stage is doing, expressed as "waiting for memory", "holding a
    // word", "faulted", with an implied one-cycle pause after reset.
    logic        m_known = 1'b0;
    logic [31:0] m_pc, m_instr;
    logic        m_waiting, m_holding, m_faulted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] redirect(input logic [31:0] pc);
        if (jalr) return (rs1_val + imm) & ~32'd1;
        if (jal || br_taken) return pc + imm;
        return pc + 32'd4;
    endfunction

    task automatic model_update();
        logic [31:0] t;
        if (!rst_n) begin
            m_known   = 1'b1;
            m_pc      = RESET_PC;
            m_instr   = NOP;
            m_waiting = 1'b0;
            m_holding = 1'b0;
            m_faulted = 1'b0;
        end else if (m_faulted) begin
            // terminal
        end else if (m_waiting) begin
            if (imem_rvalid) begin
                m_instr   = imem_rdata;
                m_waiting = 1'b0;
                m_holding = 1'b1;
            end
        end else if (!m_holding) begin
            m_waiting = 1'b1;
        end else if (retire) begin
            t = redirect(m_pc);
            m_holding = 1'b0;
            if (t[1:0] != 2'b00) m_faulted = 1'b1;
            else begin
                m_pc      = t;
                m_waiting = 1'b1;
            end
        end
    endtask

    task automatic compare();
        if (!m_known) return;
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_waiting});
        if (m_waiting) chk("imem_addr", imem_addr, m_pc);
        chk("instr", instr, m_instr);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
        chk("pc_out", pc_out, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_faulted});
    endtask

    // One clock: inputs are already set; model sees the same sampled inputs as the DUT.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    task automatic quiet();
        retire = 1'b0; br_taken = 1'b0; jal = 1'b0; jalr = 1'b0; imem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) return;
            step();
        end
        chk("wait_req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] data, input int delay);
        wait_req();
        repeat (delay) step();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        chk("lit_valid_after_rvalid", {31'd0, instr_valid}, 32'd1);
        chk("lit_instr", instr, data);
    endtask

    task automatic retire_op(input logic j, input logic jr, input logic br,
                             input logic [31:0] im, input logic [31:0] rs1);
        jal = j; jalr = jr; br_taken = br; imm = im; rs1_val = rs1; retire = 1'b1;
        step();
        quiet();
        chk("lit_valid_after_retire", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        // 1: reset, one idle cycle, then a fetch at RESET_PC
        do_reset();
        chk("lit_idle_req", {31'd0, imem_req}, 32'd0);
        chk("lit_reset_instr", instr, NOP);
        chk("lit_reset_fault", {31'd0, fetch_fault}, 32'd0);
        step();
        chk("lit_first_req", {31'd0, imem_req}, 32'd1);
        chk("lit_first_addr", imem_addr, 32'h0);
        fetch(32'h0050_0093, 3);
        chk("lit_first_pc", pc_out, 32'h0);

        // 2: sequential from 0x10
        retire_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        chk("lit_jal_0x10", imem_addr, 32'h10);
        fetch(32'h1111_1111, 0);
        retire_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lit_seq_req", {31'd0, imem_req}, 32'd1);
        chk("lit_seq_addr", imem_addr, 32'h14);

        // 3: branch back and JAL forward from 0x20
        fetch(32'h2222_2222, 1);
        retire_op(1'b1, 1'b0, 1'b0, 32'hC, 32'h0);
        chk("lit_to_0x20", imem_addr, 32'h20);
        fetch(32'h3333_3333, 2);
        retire_op(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0);
        chk("lit_branch", imem_addr, 32'h10);
        fetch(32'h4444_4444, 0);
        retire_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        fetch(32'h5555_5555, 0);
        chk("lit_pc_plus4", pc_plus4, 32'h24);
        retire_op(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        chk("lit_jal", imem_addr, 32'h120);

        // 4: JALR clears bit 0 and beats JAL
        fetch(32'h6666_6666, 1);
        retire_op(1'b0, 1'b1, 1'b0, 32'h1, 32'h1003);
        chk("lit_jalr", imem_addr, 32'h1004);
        fetch(32'h7777_7777, 0);
        retire_op(1'b1, 1'b1, 1'b0, 32'h8, 32'h2000);
        chk("lit_jalr_prio", imem_addr, 32'h2008);

        // 5: misaligned target faults; fault is terminal until reset
        fetch(32'h8888_8888, 0);
        retire_op(1'b0, 1'b1, 1'b0, 32'h0, 32'h40);
        fetch(32'h9999_9999, 0);
        retire_op(1'b1, 1'b0, 1'b0, 32'h2, 32'h0);
        chk("lit_fault", {31'd0, fetch_fault}, 32'd1);
        imem_rvalid = 1'b1; imem_rdata = 32'hAAAA_AAAA;
        step();
        imem_rvalid = 1'b0; retire = 1'b1; jal = 1'b1; imm = 32'h4;
        step();
        quiet();
        repeat (3) step();
        chk("lit_fault_req", {31'd0, imem_req}, 32'd0);
        chk("lit_fault_pc", pc_out, 32'h40);
        chk("lit_fault_sticky", {31'd0, fetch_fault}, 32'd1);
        do_reset();
        chk("lit_fault_cleared", {31'd0, fetch_fault}, 32'd0);
        step();
        chk("lit_restart_addr", imem_addr, RESET_PC);

        // 6: reset mid-fetch, stray rvalid in idle, PC wrap
        fetch(32'h0000_0013, 0);
        retire_op(1'b1, 1'b0, 1'b0, 32'h80, 32'h0);
        step();
        step();
        do_reset();
        chk("lit_midfetch_valid", {31'd0, instr_valid}, 32'd0);
        chk("lit_midfetch_pc", pc_out, RESET_PC);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("lit_stray_valid", {31'd0, instr_valid}, 32'd0);
        chk("lit_stray_instr", instr, NOP);
        fetch(32'hBBBB_BBBB, 0);
        retire_op(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
        chk("lit_top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'hCCCC_CCCC, 0);
        retire_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("lit_wrap", imem_addr, 32'h0);

        // Randomized traffic, including stray handshakes and occasional resets
        for (int c = 0; c < 4000; c++) begin
            logic [31:0] r;
            rst_n       = (fetch_fault ? ($urandom_range(0, 9) != 0)
                                       : ($urandom_range(0, 199) != 0));
            imem_rvalid = ($urandom_range(0, 99) < 30);
            imem_rdata  = $urandom;
            retire      = ($urandom_range(0, 99) < 35);
            br_taken    = $urandom_range(0, 1) != 0;
            jal         = ($urandom_range(0, 3) == 0);
            jalr        = ($urandom_range(0, 3) == 0);
            r = $urandom;
            if ($urandom_range(0, 19) != 0) r[1:0] = 2'b00;
            imm = r;
            r = $urandom;
            if ($urandom_range(0, 19) != 0) r[1] = 1'b0;
            rs1_val = r;
            step();
        end
        quiet();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
